vga_scanout: RTL and testbench

- Display-side end of the pixel interface: 640x480@60 Hz raster timing generator and DAC driver.
- Issues pixel coordinates (next_x/next_y) to the image/address logic upstream.
- Accepts the 8-bit framebuffer/ROM colour (color_in) back a fixed number of cycles later.
- Expands the colour to 24-bit RGB and drives the ADV7123-style DAC pins (hsync, vsync, blank, sync, clk) with the sync/blank pipeline aligned to the pixel data.

---
 rtl/vga_scanout.sv | 220 ++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Brief    : 640x480@60 raster timing generator and ADV7123-style DAC driver.
//            Issues fetch coordinates (next_x/next_y), takes the RRRGGGBB
//            colour back LATENCY cycles later and drives 24-bit RGB with
//            hsync/vsync/blank aligned to the pixel data.
// Options  : VGA_TEST_PATTERN_EN - adds pattern_sel; when high an 8-bar
//            test pattern replaces color_in.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int LATENCY  = 2
) (
   input  logic       clock,
   input  logic       vga_reset,
   input  logic [7:0] color_in,
`ifdef VGA_TEST_PATTERN_EN
   input  logic       pattern_sel,
`endif
   output logic [9:0] next_x,
   output logic [9:0] next_y,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic       blank,
   output logic       sync,
   output logic       clk,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue
);

   localparam int         H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] c_h_last   = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_v_last   = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
   localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
   localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       w_raw_act, w_raw_hs_n, w_raw_vs_n;
   logic       w_dly_act, w_dly_hs_n, w_dly_vs_n;
   logic [7:0] w_pix;
   logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
`ifdef VGA_TEST_PATTERN_EN
   logic [9:0] w_dly_x;
   logic [2:0] w_bar;
`endif

   // Fetch counter advance: h wraps every line, v steps on each h wrap
   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == c_h_last) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 10'd1;
      end
   end

   // Fetch counter registers; reset restarts the raster at (0,0)
   always_ff @(posedge clock) begin
      if (!vga_reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Raw timing decoded from the fetch position
   always_comb begin
      w_raw_act  = (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
      w_raw_hs_n = !((h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end));
      w_raw_vs_n = !((v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end));
   end

   // The output register is the last of the LATENCY delay stages, so only
   // LATENCY-1 pipeline stages sit in front of it.
   generate
      if (LATENCY == 1) begin : g_direct
         assign w_dly_act  = w_raw_act;
         assign w_dly_hs_n = w_raw_hs_n;
         assign w_dly_vs_n = w_raw_vs_n;
`ifdef VGA_TEST_PATTERN_EN
         assign w_dly_x    = h_cnt_q;
`endif
      end else begin : g_pipe
         localparam int c_depth = LATENCY - 1;
         logic [c_depth-1:0] act_pipe_q, act_pipe_d;
         logic [c_depth-1:0] hs_pipe_q, hs_pipe_d;
         logic [c_depth-1:0] vs_pipe_q, vs_pipe_d;
`ifdef VGA_TEST_PATTERN_EN
         logic [9:0]         x_pipe_q [c_depth];
         logic [9:0]         x_pipe_d [c_depth];
`endif

         // Shift raw timing (and x) one stage per clock
         always_comb begin
            act_pipe_d    = act_pipe_q;
            hs_pipe_d     = hs_pipe_q;
            vs_pipe_d     = vs_pipe_q;
            act_pipe_d[0] = w_raw_act;
            hs_pipe_d[0]  = w_raw_hs_n;
            vs_pipe_d[0]  = w_raw_vs_n;
            for (int i = 1; i < c_depth; i++) begin
               act_pipe_d[i] = act_pipe_q[i-1];
               hs_pipe_d[i]  = hs_pipe_q[i-1];
               vs_pipe_d[i]  = vs_pipe_q[i-1];
            end
`ifdef VGA_TEST_PATTERN_EN
            x_pipe_d[0] = h_cnt_q;
            for (int i = 1; i < c_depth; i++) begin
               x_pipe_d[i] = x_pipe_q[i-1];
            end
`endif
         end

         // Pipeline registers; cleared to blanked, sync-idle on reset
         always_ff @(posedge clock) begin
            if (!vga_reset) begin
               act_pipe_q <= '0;
               hs_pipe_q  <= '1;
               vs_pipe_q  <= '1;
`ifdef VGA_TEST_PATTERN_EN
               for (int i = 0; i < c_depth; i++) x_pipe_q[i] <= '0;
`endif
            end else begin
               act_pipe_q <= act_pipe_d;
               hs_pipe_q  <= hs_pipe_d;
               vs_pipe_q  <= vs_pipe_d;
`ifdef VGA_TEST_PATTERN_EN
               for (int i = 0; i < c_depth; i++) x_pipe_q[i] <= x_pipe_d[i];
`endif
            end
         end

         assign w_dly_act  = act_pipe_q[c_depth-1];
         assign w_dly_hs_n = hs_pipe_q[c_depth-1];
         assign w_dly_vs_n = vs_pipe_q[c_depth-1];
`ifdef VGA_TEST_PATTERN_EN
         assign w_dly_x    = x_pipe_q[c_depth-1];
`endif
      end
   endgenerate

`ifdef VGA_TEST_PATTERN_EN
   assign w_bar = 3'(w_dly_x / 10'd80);
`endif

   // Colour source select, bit-replication expansion and blanking
   always_comb begin
      w_pix = color_in;
`ifdef VGA_TEST_PATTERN_EN
      if (pattern_sel) begin
         w_pix = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
      end
`endif
      hsync_d = w_dly_hs_n;
      vsync_d = w_dly_vs_n;
      blank_d = w_dly_act;
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (w_dly_act) begin
         red_d   = {w_pix[7:5], w_pix[7:5], w_pix[7:6]};
         green_d = {w_pix[4:2], w_pix[4:2], w_pix[4:3]};
         blue_d  = {4{w_pix[1:0]}};
      end
   end

   // DAC output registers
   always_ff @(posedge clock) begin
      if (!vga_reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b0;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= blank_d;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign next_x      = h_cnt_q;
   assign next_y      = v_cnt_q;
   assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank       = blank_q;
   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign sync        = 1'b0;
   assign clk         = clock;

endmodule

`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Brief    : Self-checking bench for vga_scanout. Four instances (full
//            640x480 timing at LATENCY 2, and a shrunken raster at LATENCY
//            1, 2 and 4) share clock, reset and stimulus; a coordinate
//            history model predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

   localparam int NI = 4;
   localparam int G_LAT [NI] = '{2, 1, 2, 4};
   localparam int G_HA  [NI] = '{640, 16, 16, 16};
   localparam int G_HF  [NI] = '{16, 2, 2, 2};
   localparam int G_HS  [NI] = '{96, 4, 4, 4};
   localparam int G_HB  [NI] = '{48, 3, 3, 3};
   localparam int G_VA  [NI] = '{480, 6, 6, 6};
   localparam int G_VF  [NI] = '{10, 1, 1, 1};
   localparam int G_VS  [NI] = '{2, 2, 2, 2};
   localparam int G_VB  [NI] = '{33, 2, 2, 2};

   logic       clock = 1'b0;
   logic       vga_reset;
   logic [7:0] color_in    [NI];
`ifdef VGA_TEST_PATTERN_EN
   logic       pattern_sel;
`endif
   logic [9:0] next_x      [NI];
   logic [9:0] next_y      [NI];
   logic       frame_start [NI];
   logic       hsync       [NI];
   logic       vsync       [NI];
   logic       blank       [NI];
   logic       sync        [NI];
   logic       clk         [NI];
   logic [7:0] red         [NI];
   logic [7:0] green       [NI];
   logic [7:0] blue        [NI];

   always #5 clock = ~clock;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      vga_scanout #(
         .H_ACTIVE (G_HA[g]), .H_FP (G_HF[g]), .H_SYNC (G_HS[g]), .H_BP (G_HB[g]),
         .V_ACTIVE (G_VA[g]), .V_FP (G_VF[g]), .V_SYNC (G_VS[g]), .V_BP (G_VB[g]),
         .LATENCY  (G_LAT[g])
      ) u_dut (
         .clock       (clock),
         .vga_reset   (vga_reset),
         .color_in    (color_in[g]),
`ifdef VGA_TEST_PATTERN_EN
         .pattern_sel (pattern_sel),
`endif
         .next_x      (next_x[g]),
         .next_y      (next_y[g]),
         .frame_start (frame_start[g]),
         .hsync       (hsync[g]),
         .vsync       (vsync[g]),
         .blank       (blank[g]),
         .sync        (sync[g]),
         .clk         (clk[g]),
         .red         (red[g]),
         .green       (green[g]),
         .blue        (blue[g])
      );
   end

   // Model state: current fetch position, cycles since the last reset edge,
   // and a short history of issued coordinates (index 0 = newest).
   int   mx     [NI];
   int   my     [NI];
   int   since  [NI];
   int   hx     [NI][5];
   int   hy     [NI][5];
   int   rec656 [NI];
   logic prev_hs[NI];
   bit   model_ok = 1'b0;
   bit   pinned   = 1'b0;
   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;

   function automatic logic [23:0] expand(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
   endfunction

   function automatic logic [7:0] bar_color(input int x);
      logic [2:0] b;
      b = 3'((x / 80) % 8);
      return {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
   endfunction

   function automatic logic in_win(input int v, input int lo, input int len);
      return (v >= lo) && (v < lo + len);
   endfunction

   // Compare process: advance the model at each edge, check DUT 1 time unit later
   always @(posedge clock) begin : p_check
      logic        r;
      logic        p;
      logic [7:0]  c [NI];
      logic [49:0] exp_v;
      logic [49:0] act_v;
      logic        e_act, e_hs, e_vs;
      logic [23:0] e_rgb;
      logic [7:0]  col;
      int          x, y, l, htot, vtot;

      r = vga_reset;
      p = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      p = pattern_sel;
`endif
      for (int i = 0; i < NI; i++) c[i] = color_in[i];
      if (!r) model_ok = 1'b1;

      for (int i = 0; i < NI; i++) begin
         htot = G_HA[i] + G_HF[i] + G_HS[i] + G_HB[i];
         vtot = G_VA[i] + G_VF[i] + G_VS[i] + G_VB[i];
         if (!r) begin
            mx[i] = 0;
            my[i] = 0;
            since[i] = 0;
         end else begin
            if (since[i] < 1000) since[i] = since[i] + 1;
            mx[i] = mx[i] + 1;
            if (mx[i] == htot) begin
               mx[i] = 0;
               my[i] = (my[i] + 1 == vtot) ? 0 : my[i] + 1;
            end
         end
         for (int j = 4; j > 0; j--) begin
            hx[i][j] = hx[i][j-1];
            hy[i][j] = hy[i][j-1];
         end
         hx[i][0] = mx[i];
         hy[i][0] = my[i];
      end

      #1;

      if (model_ok) begin
         if (!pinned) begin
            pinned = 1'b1;
            checks++;
            if (expand(8'hE0) !== 24'hFF0000) begin
               errors++;
               $display("FAIL model_expand_E0: got %h want FF0000", expand(8'hE0));
            end
            checks++;
            if (expand(8'h1D) !== 24'h00FF55) begin
               errors++;
               $display("FAIL model_expand_1D: got %h want 00FF55", expand(8'h1D));
            end
            checks++;
            if ({expand(bar_color(10)), expand(bar_color(85)), expand(bar_color(600))}
                !== {24'h000000, 24'h0000FF, 24'hFFFFFF}) begin
               errors++;
               $display("FAIL model_bars: got %h %h %h want 000000 0000FF FFFFFF",
                        expand(bar_color(10)), expand(bar_color(85)), expand(bar_color(600)));
            end
         end

         for (int i = 0; i < NI; i++) begin
            l = G_LAT[i];
            if (since[i] < l) begin
               e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
            end else begin
               x     = hx[i][l];
               y     = hy[i][l];
               e_act = (x < G_HA[i]) && (y < G_VA[i]);
               e_hs  = !in_win(x, G_HA[i] + G_HF[i], G_HS[i]);
               e_vs  = !in_win(y, G_VA[i] + G_VF[i], G_VS[i]);
               col   = p ? bar_color(x) : c[i];
               e_rgb = e_act ? expand(col) : 24'h0;
            end
            exp_v = {10'(mx[i]), 10'(my[i]), (mx[i] == 0 && my[i] == 0),
                     e_hs, e_vs, e_act, 1'b0, 1'b1, e_rgb};
            act_v = {next_x[i], next_y[i], frame_start[i], hsync[i], vsync[i],
                     blank[i], sync[i], clk[i], red[i], green[i], blue[i]};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL pixel inst=%0d cyc=%0d got x=%0d y=%0d fs/hs/vs/bl/sy/ck=%b rgb=%h want x=%0d y=%0d fs/hs/vs/bl/sy/ck=%b rgb=%h",
                        i, cyc, act_v[49:40], act_v[39:30], act_v[29:24], act_v[23:0],
                        exp_v[49:40], exp_v[39:30], exp_v[29:24], exp_v[23:0]);
            end

            // Hand-computed anchors around reset release
            if (since[i] == 0) begin
               checks++;
               if ({next_x[i], next_y[i], hsync[i], vsync[i], blank[i], red[i], green[i], blue[i]}
                   !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
                  errors++;
                  $display("FAIL reset_state inst=%0d: got x=%0d y=%0d hs=%b vs=%b blank=%b rgb=%h%h%h want 0 0 1 1 0 000000",
                           i, next_x[i], next_y[i], hsync[i], vsync[i], blank[i], red[i], green[i], blue[i]);
               end
            end
            if (since[i] == l - 1 && l > 1) begin
               checks++;
               if ({blank[i], hsync[i]} !== 2'b01) begin
                  errors++;
                  $display("FAIL holdoff inst=%0d: got blank=%b hs=%b want blank=0 hs=1", i, blank[i], hsync[i]);
               end
            end
            if (since[i] == l) begin
               checks++;
               if (blank[i] !== 1'b1) begin
                  errors++;
                  $display("FAIL first_pixel inst=%0d: got blank=%b want 1 at %0d cycles after release", i, blank[i], l);
               end
            end

            // hsync falls exactly LATENCY cycles after next_x reaches the sync start
            if (since[i] >= 1 && mx[i] == G_HA[i] + G_HF[i]) rec656[i] = cyc;
            if (cyc == rec656[i] + l && since[i] >= l + 1) begin
               checks++;
               if ({prev_hs[i], hsync[i]} !== 2'b10) begin
                  errors++;
                  $display("FAIL hsync_fall inst=%0d cyc=%0d: got prev/now=%b%b want 10", i, cyc, prev_hs[i], hsync[i]);
               end
            end
            prev_hs[i] = hsync[i];
         end
      end
      cyc++;
   end

   // Stimulus: constant colour, x-following colour, random colour with random
   // resets, optional test pattern, then a clean tail.
   initial begin
      int rst_left;
      rst_left  = 0;
      for (int i = 0; i < NI; i++) begin
         color_in[i] = 8'h00;
         rec656[i]   = -100;
         prev_hs[i]  = 1'b1;
      end
`ifdef VGA_TEST_PATTERN_EN
      pattern_sel = 1'b0;
`endif
      vga_reset = 1'b0;
      repeat (4) @(negedge clock);
      vga_reset = 1'b1;

      for (int i = 0; i < NI; i++) color_in[i] = 8'hE0;
      repeat (1200) @(negedge clock);

      for (int n = 0; n < 1200; n++) begin
         @(negedge clock);
         for (int i = 0; i < NI; i++) color_in[i] = 8'(hx[i][G_LAT[i]-1]);
      end

      // Mid-frame reset held for three edges
      vga_reset = 1'b0;
      repeat (3) @(negedge clock);
      vga_reset = 1'b1;

      for (int n = 0; n < 16000; n++) begin
         @(negedge clock);
         for (int i = 0; i < NI; i++) color_in[i] = 8'($urandom);
         if (rst_left > 0) begin
            vga_reset = 1'b0;
            rst_left--;
         end else begin
            vga_reset = 1'b1;
            if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 4);
         end
      end
      @(negedge clock);
      vga_reset = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
      for (int n = 0; n < 2400; n++) begin
         @(negedge clock);
         for (int i = 0; i < NI; i++) color_in[i] = 8'($urandom);
         pattern_sel = (n < 1700) ? 1'b1 : 1'($urandom);
      end
      pattern_sel = 1'b0;
`endif

      for (int n = 0; n < 600; n++) begin
         @(negedge clock);
         for (int i = 0; i < NI; i++) color_in[i] = 8'($urandom);
      end

      @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
